cmd_tx_trailer: RTL and testbench

- Sits between the command-processing block's TX stream outputs and the 32-bit AXI4-stream TX FIFO toward the Master FPGA.
- Forwards each response frame unchanged, then appends two trailer words: a tagged word count and an XOR checksum. The final trailer word carries tlast.
- Gives the Master an integrity check on every response without changing any command state machine.

---
 rtl/cmd_tx_trailer.sv | 171 +++++++++++++++++
 tb/tb_cmd_tx_trailer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_tx_trailer.sv
// Response-stream trailer inserter: forwards each frame, then appends a tagged
// word count and an XOR checksum (the checksum word carries tlast).
module cmd_tx_trailer #(
  parameter logic [15:0] TRAILER_TAG = 16'hA55A
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        trailer_en,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic [0:3]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [15:0] frame_count,
  output logic        cnt_sat
);

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_CNT  = 2'd1,
    ST_SUM  = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [15:0] word_cnt_q,    word_cnt_d;
  logic [31:0] csum_q,        csum_d;
  logic        in_frame_q,    in_frame_d;
  logic        en_q,          en_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        cnt_sat_q,     cnt_sat_d;
  logic [31:0] m_tdata_q,     m_tdata_d;
  logic        m_tvalid_q,    m_tvalid_d;
  logic        m_tlast_q,     m_tlast_d;

  logic        slot_free_s;
  logic        s_tready_s;
  logic        en_eff_s;
  logic        at_max_s;
  logic [15:0] cnt_inc_s;
  logic [31:0] cnt_word_s;

  // Next-state, datapath and upstream-ready decode.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    csum_d        = csum_q;
    in_frame_d    = in_frame_q;
    en_d          = en_q;
    frame_count_d = frame_count_q;
    cnt_sat_d     = cnt_sat_q;
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    s_tready_s    = 1'b0;

    slot_free_s = !m_tvalid_q || m_tready;
    // The first beat of a frame uses the live enable; later beats use the latched copy.
    en_eff_s    = in_frame_q ? en_q : trailer_en;
    at_max_s    = (word_cnt_q == 16'hFFFF);
    cnt_inc_s   = at_max_s ? word_cnt_q : (word_cnt_q + 16'd1);
    cnt_word_s  = {TRAILER_TAG, word_cnt_q};

    case (state_q)
      ST_PASS: begin
        s_tready_s = slot_free_s;
        if (s_tvalid && slot_free_s) begin
          m_tdata_d  = s_tdata;
          m_tvalid_d = 1'b1;
          word_cnt_d = cnt_inc_s;
          csum_d     = csum_q ^ s_tdata;
          if (at_max_s) begin
            cnt_sat_d = 1'b1;
          end else begin
            cnt_sat_d = cnt_sat_q;
          end
          if (!in_frame_q) begin
            en_d       = trailer_en;
            in_frame_d = 1'b1;
          end else begin
            en_d       = en_q;
          end
          if (s_tlast && en_eff_s) begin
            m_tlast_d = 1'b0;
            state_d   = ST_CNT;
          end else if (s_tlast) begin
            m_tlast_d     = 1'b1;
            word_cnt_d    = 16'd0;
            csum_d        = 32'd0;
            in_frame_d    = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            m_tlast_d = 1'b0;
          end
        end else if (m_tready) begin
          m_tvalid_d = 1'b0;
        end else begin
          m_tvalid_d = m_tvalid_q;
        end
      end
      ST_CNT: begin
        if (slot_free_s) begin
          m_tdata_d  = cnt_word_s;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          csum_d     = csum_q ^ cnt_word_s;
          state_d    = ST_SUM;
        end else begin
          state_d    = ST_CNT;
        end
      end
      ST_SUM: begin
        if (slot_free_s) begin
          m_tdata_d     = csum_q;
          m_tvalid_d    = 1'b1;
          m_tlast_d     = 1'b1;
          word_cnt_d    = 16'd0;
          csum_d        = 32'd0;
          in_frame_d    = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_PASS;
        end else begin
          state_d       = ST_SUM;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_PASS;
      word_cnt_q    <= 16'd0;
      csum_q        <= 32'd0;
      in_frame_q    <= 1'b0;
      en_q          <= 1'b0;
      frame_count_q <= 16'd0;
      cnt_sat_q     <= 1'b0;
      m_tdata_q     <= 32'd0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      csum_q        <= csum_d;
      in_frame_q    <= in_frame_d;
      en_q          <= en_d;
      frame_count_q <= frame_count_d;
      cnt_sat_q     <= cnt_sat_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
    end
  end

  // Ready is forced low while reset is held, since the empty slot would otherwise look free.
  assign s_tready    = resetN && s_tready_s;
  assign m_tdata     = m_tdata_q;
  assign m_tvalid    = m_tvalid_q;
  assign m_tlast     = m_tlast_q;
  assign m_tkeep     = 4'b1111;
  assign frame_count = frame_count_q;
  assign cnt_sat     = cnt_sat_q;

endmodule

// File: tb/tb_cmd_tx_trailer.sv
// Scoreboard bench for cmd_tx_trailer: expected beats are queued as frames are
// driven and compared as the output port transfers them.
module tb_cmd_tx_trailer;

  logic        clk;
  logic        resetN;
  logic        trailer_en;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [0:3]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] frame_count;
  logic        cnt_sat;

  logic [32:0] sb_q[$];
  int          n_checks;
  int          n_pass;
  int          exp_frames;

  cmd_tx_trailer dut (
    .clk         (clk),
    .resetN      (resetN),
    .trailer_en  (trailer_en),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .frame_count (frame_count),
    .cnt_sat     (cnt_sat)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a beat seen valid and ready at the negedge transfers on the next posedge.
  always @(negedge clk) begin
    if (resetN && m_tvalid && m_tready) begin
      check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        check_val("beat", 64'({m_tlast, m_tdata}), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic last);
    logic acc;
    acc      = 1'b0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [31:0] w[$], input logic en, input logic flip);
    logic [31:0] cs;
    logic [15:0] cnt;
    logic [31:0] cw;
    cs = 32'd0;
    cnt = 16'd0;
    trailer_en = en;
    for (int i = 0; i < w.size(); i++) begin
      sb_q.push_back({(i == w.size() - 1) && !en, w[i]});
      cs = cs ^ w[i];
      if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
      drive_beat(w[i], i == w.size() - 1);
      if (i == 0 && flip) trailer_en = !en;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (en) begin
      cw = {16'hA55A, cnt};
      sb_q.push_back({1'b0, cw});
      sb_q.push_back({1'b1, cs ^ cw});
    end
    exp_frames++;
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 500; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #2;
    end
    check_val(tag, 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] fr[$];
    n_checks = 0; n_pass = 0; exp_frames = 0;
    resetN = 1'b0; trailer_en = 1'b0; s_tdata = 32'd0; s_tvalid = 1'b0;
    s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_val("rst_tlast", 64'(m_tlast), 64'd0);
    check_val("rst_tdata", 64'(m_tdata), 64'd0);
    check_val("rst_fcount", 64'(frame_count), 64'd0);
    check_val("rst_sat", 64'(cnt_sat), 64'd0);
    check_val("rst_sready", 64'(s_tready), 64'd0);
    check_val("tkeep", 64'(m_tkeep), 64'hF);
    resetN = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;

    fr = '{32'h1, 32'h2, 32'h4};
    send_frame(fr, 1'b1, 1'b0);
    wait_drain("basic_drain");
    check_val("basic_fcount", 64'(frame_count), 64'(exp_frames));

    fr = '{32'h12345678};
    send_frame(fr, 1'b1, 1'b0);
    wait_drain("single_drain");

    fr = '{32'hDEADBEEF, 32'h0BADF00D, 32'h55AA55AA};
    send_frame(fr, 1'b0, 1'b0);
    wait_drain("pass_drain");
    check_val("pass_fcount", 64'(frame_count), 64'(exp_frames));

    // Stall with the count word held in the output slot.
    fr = '{32'h1, 32'h2, 32'h4};
    send_frame(fr, 1'b1, 1'b0);
    @(posedge clk); #1;
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_tdata", 64'(m_tdata), 64'hA55A0003);
      check_val("bp_tvalid", 64'(m_tvalid), 64'd1);
      check_val("bp_sready", 64'(s_tready), 64'd0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_drain("bp_drain");
    check_val("bp_fcount", 64'(frame_count), 64'(exp_frames));

    fr = '{32'hA, 32'hB, 32'hC};
    send_frame(fr, 1'b1, 1'b1);
    wait_drain("flip_on_drain");
    fr = '{32'h11, 32'h22};
    send_frame(fr, 1'b0, 1'b1);
    wait_drain("flip_off_drain");
    check_val("cnt_sat_clear", 64'(cnt_sat), 64'd0);

    // Reset while the checksum word is pending.
    fr = '{32'h7, 32'h8};
    send_frame(fr, 1'b1, 1'b0);
    @(posedge clk); #1;
    m_tready = 1'b0;
    check_val("pre_rst_fcount", 64'(frame_count), 64'(exp_frames - 1));
    resetN = 1'b0;
    #1;
    check_val("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    check_val("mid_rst_fcount", 64'(frame_count), 64'd0);
    sb_q.delete();
    exp_frames = 0;
    @(posedge clk); #1;
    resetN = 1'b1; m_tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("post_rst_idle", 64'(m_tvalid), 64'd0);
    end
    @(posedge clk); #1;
    fr = '{32'hCAFE0001, 32'hCAFE0002};
    send_frame(fr, 1'b1, 1'b0);
    wait_drain("post_rst_drain");
    check_val("post_rst_fcount", 64'(frame_count), 64'd1);

    fr.delete();
    for (int i = 0; i < 65537; i++) fr.push_back(32'(i) ^ 32'h3C000000);
    send_frame(fr, 1'b1, 1'b0);
    wait_drain("sat_drain");
    check_val("sat_flag", 64'(cnt_sat), 64'd1);
    check_val("sat_fcount", 64'(frame_count), 64'(exp_frames));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
